memory_read_responder: RTL

- Slave/responder end of the memory read channel: receives the single arbitrated read request stream (addr/valid) and returns data with a one-cycle ready pulse.
- Its request/ready/data ports connect directly to the arbiter-side memory read port of the coprocessor mesh.
- Wraps the instruction RAM with a configurable read latency.
- Provides a host write port for loading programs, out-of-range detection and a served-reads counter.

---
 rtl/memory_read_responder_if.sv | 18 +
 rtl/memory_read_responder.sv | 63 ++++++
 2 files changed

// File: rtl/memory_read_responder_if.sv
// memory_read_responder_if: read request channel and host write port shared by requester and responder
interface memory_read_responder_if #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11
);
  logic [MEMORY_ADDR_WIDTH-1:0] req_addr;
  logic                         req_valid;
  logic                         req_ready;
  logic [MEMORY_WIDTH-1:0]      req_data;
  logic                         wr_en;
  logic [MEMORY_ADDR_WIDTH-1:0] wr_addr;
  logic [MEMORY_WIDTH-1:0]      wr_data;
  logic                         wr_ready;
  modport master (output req_addr, req_valid, wr_en, wr_addr, wr_data,
                  input  req_ready, req_data, wr_ready);
  modport slave  (input  req_addr, req_valid, wr_en, wr_addr, wr_data,
                  output req_ready, req_data, wr_ready);
endinterface

// File: rtl/memory_read_responder.sv
// memory_read_responder: instruction RAM behind a fixed-latency read responder with host write port
module memory_read_responder #(
  parameter int MEMORY_WIDTH      = 16,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_DEPTH      = 2**MEMORY_ADDR_WIDTH,
  parameter int READ_LATENCY      = 2,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_read_responder_if.slave bus,
  output logic                   busy,
  output logic                   addr_err,
  output logic [COUNT_WIDTH-1:0] reads_served
);
  localparam int IW = MEMORY_DEPTH > 1 ? $clog2(MEMORY_DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [MEMORY_WIDTH-1:0] data_q, data_d;
  logic                    addr_err_q, addr_err_d;
  logic [COUNT_WIDTH-1:0]  reads_q, reads_d;
  logic                    accept, rd_oor, we;
  logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];
  // Data is read at accept time; writes are locked out until IDLE, so it cannot go stale.
  always_comb begin
    accept     = state_q == IDLE && !bus.wr_en && bus.req_valid;
    rd_oor     = 32'(bus.req_addr) >= MEMORY_DEPTH;
    we         = bus.wr_ready && bus.wr_en && 32'(bus.wr_addr) < MEMORY_DEPTH;
    state_d    = accept ? (READ_LATENCY > 1 ? WAIT : RESP) :
                 state_q == WAIT ? (cnt_q == '0 ? RESP : WAIT) :
                 state_q == RESP ? IDLE : state_q;
    cnt_d      = accept ? 2'(READ_LATENCY > 1 ? READ_LATENCY - 2 : 0) :
                 (state_q == WAIT && cnt_q != '0) ? cnt_q - 2'd1 : cnt_q;
    data_d     = accept ? (rd_oor ? '0 : mem[bus.req_addr[IW-1:0]]) : data_q;
    addr_err_d = addr_err_q | (accept & rd_oor);
    reads_d    = (state_q == RESP && reads_q != '1) ? reads_q + 1'b1 : reads_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      addr_err_q <= 1'b0;
      reads_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      addr_err_q <= addr_err_d;
      reads_q    <= reads_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[bus.wr_addr[IW-1:0]] <= bus.wr_data;
  end
  assign bus.req_ready = state_q == RESP;
  assign bus.req_data  = bus.req_ready ? data_q : '0;
  assign bus.wr_ready  = rst && state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign addr_err      = addr_err_q;
  assign reads_served  = reads_q;
endmodule
